// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the I-side and D-side cache
// engines. Whole transactions are serialised. The memory request and address
// are held for MEM_LATENCY cycles. Read data and a one-cycle done pulse go
// back to the winning side. Simultaneous requests are arbitrated round-robin.
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   i_req/i_we/i_addr/i_wdata    I-side request (level, held until i_done)
//   i_rdata, i_done              I-side registered read data, done pulse
//   d_req/d_we/d_addr/d_wdata    D-side request
//   d_rdata, d_done              D-side registered read data, done pulse
//   m_read_req, m_write_req      memory request strobes (registered)
//   m_addr, m_wdata, m_rdata     memory address/write data/read data
//   busy                         transaction in progress (ACCESS or DONE)
//   grant_d                      owner of current/last transaction (1 = D)
//   conflict_cnt                 IDLE cycles with both requests seen (wraps)
//
// state  | meaning
// IDLE   | waiting for a request; arbitrates and latches the winner
// ACCESS | memory request held; cnt counts down to the last access cycle
// DONE   | winner's done pulse is high; requests are ignored
module mem_arbiter #(
  parameter int WORD_SIZE   = 16,
  parameter int MEM_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic                 i_we,
  input  logic [WORD_SIZE-1:0] i_addr,
  input  logic [WORD_SIZE-1:0] i_wdata,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_done,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_done,
  output logic                 m_read_req,
  output logic                 m_write_req,
  output logic [WORD_SIZE-1:0] m_addr,
  output logic [WORD_SIZE-1:0] m_wdata,
  input  logic [WORD_SIZE-1:0] m_rdata,
  output logic                 busy,
  output logic                 grant_d,
  output logic [15:0]          conflict_cnt
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

  state_t               state, state_nxt;
  logic [3:0]           cnt;
  logic                 lat_we;
  logic [WORD_SIZE-1:0] lat_addr, lat_wdata;
  logic                 last_d;

  logic                 grant_go, win_d, both_req, access_end;
  logic                 win_we;
  logic [WORD_SIZE-1:0] win_addr, win_wdata;

  always_comb begin
    state_nxt  = state;
    grant_go   = 1'b0;
    win_d      = 1'b0;
    both_req   = 1'b0;
    access_end = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_req || d_req) begin
          grant_go  = 1'b1;
          state_nxt = ST_ACCESS;
          if (i_req && d_req) begin
            both_req = 1'b1;
            // round-robin: the side that did not win last time goes first
            win_d    = ~last_d;
          end else begin
            win_d    = d_req;
          end
        end
      end
      ST_ACCESS: begin
        if (cnt == 4'd0) begin
          access_end = 1'b1;
          state_nxt  = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    win_we    = win_d ? d_we    : i_we;
    win_addr  = win_d ? d_addr  : i_addr;
    win_wdata = win_d ? d_wdata : i_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      cnt          <= 4'd0;
      lat_we       <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      last_d       <= 1'b1;
      grant_d      <= 1'b0;
      m_read_req   <= 1'b0;
      m_write_req  <= 1'b0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      i_done       <= 1'b0;
      d_done       <= 1'b0;
      conflict_cnt <= 16'd0;
    end else begin
      state  <= state_nxt;
      i_done <= 1'b0;
      d_done <= 1'b0;
      if (grant_go) begin
        lat_we      <= win_we;
        lat_addr    <= win_addr;
        lat_wdata   <= win_wdata;
        last_d      <= win_d;
        grant_d     <= win_d;
        cnt         <= CNT_LOAD;
        m_read_req  <= ~win_we;
        m_write_req <= win_we;
        if (both_req) conflict_cnt <= conflict_cnt + 16'd1;
      end
      if (state == ST_ACCESS) begin
        if (access_end) begin
          m_read_req  <= 1'b0;
          m_write_req <= 1'b0;
          if (!lat_we) begin
            if (grant_d) d_rdata <= m_rdata;
            else         i_rdata <= m_rdata;
          end
          if (grant_d) d_done <= 1'b1;
          else         i_done <= 1'b1;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

  assign m_addr  = lat_addr;
  assign m_wdata = lat_wdata;
  assign busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int W = 16;
  localparam int LAT [2] = '{4, 1};

  logic clk = 1'b0;
  logic reset_n;
  logic i_req, i_we, d_req, d_we;
  logic [W-1:0] i_addr, i_wdata, d_addr, d_wdata;
  logic [1:0][W-1:0] m_rdata;

  wire [1:0][W-1:0] i_rdata, d_rdata, m_addr, m_wdata;
  wire [1:0][15:0]  conflict_cnt;
  wire [1:0]        i_done, d_done, m_read_req, m_write_req, busy, grant_d;

  int checks = 0;
  int errors = 0;

  // reference model state, one set per DUT (index 0: latency 4, 1: latency 1)
  bit         mact [2];
  int         mt   [2];
  bit         mown [2], mwe [2], mlast [2], mgd [2], midone [2], mddone [2];
  logic [W-1:0] maddr [2], mwd [2], mir [2], mdr [2];
  logic [15:0]  mconf [2];

  always #5 clk = ~clk;

  mem_arbiter #(.WORD_SIZE(W), .MEM_LATENCY(4)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata[0]), .i_done(i_done[0]),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata[0]), .d_done(d_done[0]),
    .m_read_req(m_read_req[0]), .m_write_req(m_write_req[0]),
    .m_addr(m_addr[0]), .m_wdata(m_wdata[0]), .m_rdata(m_rdata[0]),
    .busy(busy[0]), .grant_d(grant_d[0]), .conflict_cnt(conflict_cnt[0])
  );

  mem_arbiter #(.WORD_SIZE(W), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata[1]), .i_done(i_done[1]),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata[1]), .d_done(d_done[1]),
    .m_read_req(m_read_req[1]), .m_write_req(m_write_req[1]),
    .m_addr(m_addr[1]), .m_wdata(m_wdata[1]), .m_rdata(m_rdata[1]),
    .busy(busy[1]), .grant_d(grant_d[1]), .conflict_cnt(conflict_cnt[1])
  );

  function automatic logic [W-1:0] mem_val(input logic [W-1:0] a);
    if (a == 16'h0010) return 16'h1234;
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%h expected=%h t=%0t", tag, k, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mact[k] = 0; mt[k] = 0; mown[k] = 0; mwe[k] = 0;
      mlast[k] = 1; mgd[k] = 0; midone[k] = 0; mddone[k] = 0;
      maddr[k] = '0; mwd[k] = '0; mir[k] = '0; mdr[k] = '0; mconf[k] = '0;
      m_rdata[k] = 16'hDEAD;
    end
  endtask

  // Timeline model: a transaction granted at edge N owns the memory for
  // edges N+1..N+L, finishes (done) after edge N+L, and the arbiter is free
  // to grant again from edge N+L+2.
  task automatic model_edge();
    bit w;
    if (!reset_n) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      midone[k] = 0; mddone[k] = 0;
      if (!mact[k]) begin
        if (i_req || d_req) begin
          w = (i_req && d_req) ? !mlast[k] : d_req;
          if (i_req && d_req) mconf[k] = mconf[k] + 16'd1;
          mown[k] = w; mlast[k] = w; mgd[k] = w;
          mwe[k]   = w ? d_we : i_we;
          maddr[k] = w ? d_addr : i_addr;
          mwd[k]   = w ? d_wdata : i_wdata;
          mact[k]  = 1; mt[k] = 1;
        end
      end else begin
        mt[k]++;
        if (mt[k] == LAT[k] + 1) begin
          if (!mwe[k]) begin
            if (mown[k]) mdr[k] = mem_val(maddr[k]);
            else         mir[k] = mem_val(maddr[k]);
          end
          if (mown[k]) mddone[k] = 1;
          else         midone[k] = 1;
        end else if (mt[k] == LAT[k] + 2) begin
          mact[k] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk("m_read_req",   k, m_read_req[k],  mact[k] && mt[k] <= LAT[k] && !mwe[k]);
      chk("m_write_req",  k, m_write_req[k], mact[k] && mt[k] <= LAT[k] && mwe[k]);
      chk("m_addr",       k, m_addr[k],      maddr[k]);
      chk("m_wdata",      k, m_wdata[k],     mwd[k]);
      chk("i_done",       k, i_done[k],      midone[k]);
      chk("d_done",       k, d_done[k],      mddone[k]);
      chk("i_rdata",      k, i_rdata[k],     mir[k]);
      chk("d_rdata",      k, d_rdata[k],     mdr[k]);
      chk("busy",         k, busy[k],        mact[k]);
      chk("grant_d",      k, grant_d[k],     mgd[k]);
      chk("conflict_cnt", k, conflict_cnt[k], mconf[k]);
    end
  endtask

  // memory returns valid data only in the last access cycle
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < 2; k++)
      m_rdata[k] = (mact[k] && mt[k] == LAT[k]) ? mem_val(maddr[k]) : 16'hDEAD;
    check_all();
  endtask

  // each requester drops req on the cycle its done (latency-4 DUT) is seen
  task automatic hold_until_done(input int budget);
    int n = 0;
    while ((i_req || d_req) && n < budget) begin
      cyc();
      n++;
      if (midone[0]) i_req = 0;
      if (mddone[0]) d_req = 0;
    end
    chk("req_timeout", 0, {31'd0, i_req | d_req}, 32'd0);
  endtask

  task automatic async_reset();
    #2 reset_n = 0;
    model_reset();
    #1 check_all();
    i_req = 0; d_req = 0;
    cyc();
    reset_n = 1;
  endtask

  initial begin
    int dcnt, icnt;
    reset_n = 0;
    i_req = 0; i_we = 0; i_addr = '0; i_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    model_reset();
    #1 check_all();
    cyc(); cyc();
    reset_n = 1;
    cyc();

    // 1: I read of 0x0010
    i_req = 1; i_we = 0; i_addr = 16'h0010;
    hold_until_done(20);
    chk("t1_i_rdata", 0, i_rdata[0], 16'h1234);
    chk("t1_d_rdata", 0, d_rdata[0], 16'h0000);
    cyc(); cyc(); cyc();

    // 2: D write 0xBEEF to 0x0044
    d_req = 1; d_we = 1; d_addr = 16'h0044; d_wdata = 16'hBEEF;
    hold_until_done(20);
    chk("t2_d_rdata", 0, d_rdata[0], 16'h0000);
    cyc(); cyc(); cyc();

    // 3: simultaneous requests from a fresh reset; I wins first
    reset_n = 0; model_reset(); cyc(); reset_n = 1; cyc();
    i_req = 1; i_we = 0; i_addr = 16'h0123;
    d_req = 1; d_we = 0; d_addr = 16'h0456;
    cyc();
    chk("t3_first_grant", 0, grant_d[0], 1'b0);
    hold_until_done(30);
    chk("t3_conflicts", 0, conflict_cnt[0], 16'd1);
    chk("t3_last_grant", 0, grant_d[0], 1'b1);
    cyc(); cyc(); cyc();

    // 4: both sides hold req through four transactions
    i_req = 1; d_req = 1; i_we = 1; d_we = 0;
    icnt = 0; dcnt = 0;
    for (int n = 0; n < 24; n++) begin
      cyc();
      icnt += int'(i_done[0]); dcnt += int'(d_done[0]);
    end
    i_req = 0; d_req = 0;
    chk("t4_i_count", 0, icnt, 2);
    chk("t4_d_count", 0, dcnt, 2);
    cyc(); cyc(); cyc(); cyc(); cyc(); cyc();

    // 5: D changes address and drops req mid-access
    d_req = 1; d_we = 0; d_addr = 16'h0200;
    cyc(); cyc();
    d_addr = 16'h0300; d_req = 0;
    dcnt = 0;
    for (int n = 0; n < 6; n++) begin
      cyc();
      dcnt += int'(d_done[0]);
      if (n == 0) chk("t5_m_addr", 0, m_addr[0], 16'h0200);
    end
    chk("t5_d_pulses", 0, dcnt, 1);

    // 6: reset in the second access cycle, then a clean transaction
    i_req = 1; i_we = 0; i_addr = 16'h0010;
    cyc(); cyc();
    async_reset();
    chk("t6_rdreq", 0, m_read_req[0], 1'b0);
    cyc(); cyc(); cyc();
    i_req = 1; i_we = 0; i_addr = 16'h0010;
    hold_until_done(20);
    chk("t6_i_rdata", 0, i_rdata[0], 16'h1234);

    // randomized traffic with occasional asynchronous reset
    for (int n = 0; n < 600; n++) begin
      i_req = ($urandom_range(0, 3) != 0); i_we = 1'($urandom_range(0, 1));
      d_req = ($urandom_range(0, 3) != 0); d_we = 1'($urandom_range(0, 1));
      i_addr = 16'($urandom); i_wdata = 16'($urandom);
      d_addr = 16'($urandom); d_wdata = 16'($urandom);
      if ($urandom_range(0, 149) == 0) async_reset();
      else cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
